// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal shift register with parallel load, run-time direction and frame counter
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] pi,
  input  logic             si,
  output logic             so,
  output logic [WIDTH-1:0] po,
  output logic [CW-1:0]    cnt,
  output logic             frame_done
);
  logic [WIDTH-1:0] q;
  logic last;
  assign last = cnt == CW'(WIDTH - 1);
  assign so = dir ? q[WIDTH-1] : q[0];
  assign po = q;
  always_ff @(posedge CLK) begin
    if (RES) begin
      q <= RESET_VAL;
      cnt <= '0;
      frame_done <= 1'b0;
    end else if (load) begin
      q <= pi;
      cnt <= '0;
      frame_done <= 1'b0;
    end else if (en) begin
      q <= dir ? {q[WIDTH-2:0], si} : {si, q[WIDTH-1:1]};
      cnt <= last ? '0 : cnt + 1'b1;
      frame_done <= last;
    end else begin
      frame_done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed self-checking bench for univ_shift_reg (WIDTH=8, RESET_VAL=0)
module tb_univ_shift_reg;
  logic clk = 1'b0;
  logic res, en, dir, load, si, so, frame_done;
  logic [7:0] pi, po;
  logic [2:0] cnt;
  logic [7:0] sipo_bits;
  logic [7:0] a5;
  logic [23:0] stream;
  int n_cmp = 0;
  int n_err = 0;

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .CLK(clk), .RES(res), .en(en), .dir(dir), .load(load), .pi(pi), .si(si),
    .so(so), .po(po), .cnt(cnt), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    res = 1'b1; en = 1'b1; dir = 1'b0; load = 1'b1; si = 1'b1; pi = 8'($urandom);
    tick();
    chk("rst_po", 32'(po), 0);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_fd", 32'(frame_done), 0);
    chk("rst_so_r", 32'(so), 0);
    dir = 1'b1; #1;
    chk("rst_so_l", 32'(so), 0);
    res = 1'b0; load = 1'b0; dir = 1'b0;

    // SIPO right: first bit first ends up in the LSB
    sipo_bits = 8'b0100_1101;
    for (int i = 0; i < 8; i++) begin
      si = sipo_bits[i];
      tick();
      chk("sipo_cnt", 32'(cnt), (i + 1) % 8);
      chk("sipo_fd", 32'(frame_done), (i == 7) ? 1 : 0);
    end
    chk("sipo_po", 32'(po), 32'h4D);
    en = 1'b0;
    tick();
    chk("sipo_fd_drop", 32'(frame_done), 0);

    // PISO left
    a5 = 8'hA5;
    load = 1'b1; pi = a5;
    tick();
    chk("piso_po_load", 32'(po), 32'hA5);
    chk("piso_cnt_load", 32'(cnt), 0);
    load = 1'b0; dir = 1'b1; #1;
    chk("piso_so0", 32'(so), 1);
    en = 1'b1; si = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k < 8) chk("piso_so", 32'(so), 32'(a5[7-k]));
      chk("piso_fd", 32'(frame_done), (k == 8) ? 1 : 0);
    end
    chk("piso_po_end", 32'(po), 0);

    // reset mid-frame discards the partial frame
    dir = 1'b0; si = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("midrst_pre_cnt", 32'(cnt), 3);
    res = 1'b1;
    tick();
    chk("midrst_po", 32'(po), 0);
    chk("midrst_cnt", 32'(cnt), 0);
    chk("midrst_fd", 32'(frame_done), 0);
    res = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("midrst_fd_after", 32'(frame_done), (i == 8) ? 1 : 0);
      chk("midrst_cnt_after", 32'(cnt), i % 8);
    end

    // SISO delay of 8 cycles from a clean register
    res = 1'b1;
    tick();
    res = 1'b0; dir = 1'b0; en = 1'b1;
    stream = 24'($urandom);
    for (int n = 1; n <= 24; n++) begin
      si = stream[n-1];
      tick();
      chk("siso_so", 32'(so), (n >= 8) ? 32'(stream[n-8]) : 0);
      chk("siso_fd", 32'(frame_done), (n % 8 == 0) ? 1 : 0);
    end

    // load beats en, then hold
    load = 1'b1; en = 1'b1; pi = 8'h3C; si = 1'b1;
    tick();
    chk("prio_po", 32'(po), 32'h3C);
    chk("prio_cnt", 32'(cnt), 0);
    chk("prio_fd", 32'(frame_done), 0);
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_po", 32'(po), 32'h3C);
      chk("hold_cnt", 32'(cnt), 0);
      chk("hold_so", 32'(so), 0);
      chk("hold_fd", 32'(frame_done), 0);
    end

    // direction change mid-frame keeps the count running
    load = 1'b1; pi = 8'h81;
    tick();
    load = 1'b0; en = 1'b1; dir = 1'b0; si = 1'b0;
    tick();
    chk("dir_po1", 32'(po), 32'h40);
    tick();
    chk("dir_po2", 32'(po), 32'h20);
    chk("dir_cnt2", 32'(cnt), 2);
    dir = 1'b1;
    for (int i = 3; i <= 8; i++) begin
      tick();
      chk("dir_cnt", 32'(cnt), i % 8);
      chk("dir_fd", 32'(frame_done), (i == 8) ? 1 : 0);
      if (i == 3) chk("dir_po3", 32'(po), 32'h40);
    end
    chk("dir_po_end", 32'(po), 0);
    en = 1'b0;
    tick();
    chk("dir_fd_drop", 32'(frame_done), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register that generalises the fixed serial-in/serial-out stage into one block. It supports SISO, SIPO, PISO and PIPO use, with a run-time shift direction, a parallel load, a shift-enable and a frame counter. A one-cycle `frame_done` pulse marks every WIDTH-th shift. It sits between serial links (UART/SPI-style bit streams) and word-wide datapaths in the design.

## Interface
Parameters:
- `WIDTH`, default 8: register width in bits; legal range is WIDTH ≥ 2.
- `RESET_VAL`, default 0: value loaded into the data register on reset (WIDTH bits).

Derived: `CW = $clog2(WIDTH)` is the counter width.

Ports:
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RES`  in  1  synchronous, active-high reset; highest priority.
- `en`  in  1  shift enable.
- `dir`  in  1  shift direction.
  - 0 = right: `si` enters the MSB and `so` is the LSB.
  - 1 = left: `si` enters the LSB and `so` is the MSB.
- `load`  in  1  parallel load of `pi`; has priority over `en`.
- `pi`  in  WIDTH  parallel input.
- `si`  in  1  serial input.
- `so`  out  1  serial output.
- `po`  out  WIDTH  parallel output (the data register `q`).
- `cnt`  out  CW  number of shifts since the last frame boundary, load or reset.
- `frame_done`  out  1  registered pulse, high for one cycle after every WIDTH-th shift.

## Operation
Per rising edge, evaluated in priority order:
1. `RES`=1: `q`←RESET_VAL, `cnt`←0, `frame_done`←0. All other inputs are ignored.
2. `load`=1: `q`←`pi`, `cnt`←0, `frame_done`←0. `en` is ignored.
3. `en`=1: shift according to `dir`.
   - `dir`=0: `q`←{`si`, `q`[WIDTH-1:1]}.
   - `dir`=1: `q`←{`q`[WIDTH-2:0], `si`}.
   - If `cnt`==WIDTH-1: `cnt`←0 and `frame_done`←1.
   - Otherwise: `cnt`←`cnt`+1 and `frame_done`←0.
4. Otherwise: `q` and `cnt` hold; `frame_done`←0.

Outputs:
- `so` = `dir` ? `q`[WIDTH-1] : `q`[0]. This is combinational from `q` and `dir`; there is no extra register.
- `po` = `q`.

Boundary rules:
- `cnt` wraps from WIDTH-1 to 0 and never reaches WIDTH.
- `frame_done` is never high for two consecutive cycles unless `en` stays high and WIDTH shifts complete back-to-back. That cannot happen for WIDTH ≥ 2, so the pulse is always exactly one cycle.
- A change of `dir` mid-frame takes effect at the next shift. `cnt` continues and is not cleared.
- `load` mid-frame discards the partial frame: `cnt`←0 and no `frame_done`.
- `RES` mid-frame discards the partial frame. The next `frame_done` needs WIDTH further shifts.
- `load` and `en` asserted together: the load wins and no shift happens on that edge.

## Timing
- Reset values: `po`=RESET_VAL, `cnt`=0, `frame_done`=0, `so`=RESET_VAL bit selected by `dir`.
- Reset takes effect on the first rising edge with `RES`=1. There is no asynchronous path.
- Latencies:
  - Serial-in to `so` (SISO): WIDTH cycles.
  - Serial-in to full word on `po` (SIPO): WIDTH edges.
  - Load to first serial bit on `so`: 0 cycles (visible right after the load edge).
- `frame_done` goes high in the cycle immediately after the edge that performed the WIDTH-th shift. That is the same cycle in which `po` holds the complete frame. It drops on the next edge.
- Throughput: one bit per cycle while `en`=1. There are no bubbles at frame boundaries.

## Test plan
All scenarios use WIDTH=8 and RESET_VAL=0.
- **Reset:** drive random `pi`, `si`, `load`, `en`, then `RES`=1 for one edge → `po`=0x00, `cnt`=0, `frame_done`=0, `so`=0. Repeat with `RES` asserted mid-frame after 3 shifts → same values, and `frame_done` fires only after 8 further shifts.
- **SIPO right:** `dir`=0, `en`=1, `si` = 1,0,1,1,0,0,1,0 (first bit first) → after 8 edges `po`=0x4D, `frame_done`=1 for exactly that cycle, `cnt`=0. `cnt` steps 1..7 on the preceding edges.
- **PISO left:** `load`=1 with `pi`=0xA5, then `dir`=1, `en`=1, `si`=0 for 8 edges → `so` sequence 1,0,1,0,0,1,0,1 (first value valid before the first shift), final `po`=0x00, one `frame_done` pulse.
- **SISO delay:** `dir`=0, `en`=1, 24-bit pseudo-random `si` stream → `so` equals `si` delayed by 8 cycles, and `frame_done` pulses at edges 8, 16 and 24.
- **Priority and hold:** `load`=1 and `en`=1 on the same edge with `pi`=0x3C → `po`=0x3C, `cnt`=0. Then `en`=0 for 5 cycles → `po`, `cnt` and `so` unchanged, `frame_done`=0.
- **Direction change mid-frame:** load 0x81, shift right 2 with `si`=0, switch `dir`=1, shift 6 more with `si`=0 → `po`=0x00, `cnt` counts continuously 1..7 then wraps to 0, and `frame_done` pulses once after the 8th shift.
